// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave time-entry controller.
package microwave_pkg;

  // FSM state encodings; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Keypad command codes; 0-9 are digits, 13-15 carry no meaning.
  localparam logic [3:0] KEY_START = 4'd10;
  localparam logic [3:0] KEY_STOP  = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  // Number of digits the MM:SS display can hold.
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // Single BCD digit decrement with wrap from 0 to 9.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : (d - 4'd1);
  endfunction

endpackage

// File: rtl/mmss_decrement.sv
// Combinational one-second decrement of a BCD MM:SS value.
// Seconds tens above 5 (e.g. an entered 0:99) are decremented as-is; only a
// borrow out of the seconds field reloads it to 59. A 00:00 input is held.
module mmss_decrement
  import microwave_pkg::*;
(
  input  logic [3:0] i_min_tens,
  input  logic [3:0] i_min_ones,
  input  logic [3:0] i_sec_tens,
  input  logic [3:0] i_sec_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_zero
);

  logic w_in_zero;

  assign w_in_zero = (i_min_tens == 4'd0) && (i_min_ones == 4'd0) &&
                     (i_sec_tens == 4'd0) && (i_sec_ones == 4'd0);

  // Borrow ripples from seconds ones up through the minutes.
  always_comb begin
    o_min_tens = i_min_tens;
    o_min_ones = i_min_ones;
    o_sec_tens = i_sec_tens;
    o_sec_ones = i_sec_ones;
    if (!w_in_zero) begin
      if (i_sec_ones != 4'd0) begin
        o_sec_ones = i_sec_ones - 4'd1;
      end else if (i_sec_tens != 4'd0) begin
        o_sec_ones = 4'd9;
        o_sec_tens = i_sec_tens - 4'd1;
      end else begin
        o_sec_ones = 4'd9;
        o_sec_tens = 4'd5;
        o_min_ones = bcd_dec(i_min_ones);
        if (i_min_ones == 4'd0) begin
          o_min_tens = i_min_tens - 4'd1;
        end
      end
    end
  end

  // Result flag used by the controller to detect the end of the cook.
  always_comb begin
    o_zero = (o_min_tens == 4'd0) && (o_min_ones == 4'd0) &&
             (o_sec_tens == 4'd0) && (o_sec_ones == 4'd0);
  end

endmodule

// File: rtl/time_entry_counter.sv
// Microwave keypad time entry, countdown and done-hold controller.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | display 00:00, no digits entered, waiting for a digit
//   ST_ENTRY | digits being keyed in, waiting for START
//   ST_RUN   | heating, MM:SS decremented once per tick_1hz
//   ST_PAUSE | cook interrupted by STOP or open door, time retained
//   ST_DONE  | countdown finished, done held for DONE_TICKS ticks
module time_entry_counter
  import microwave_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_pulse,
  input  logic [3:0] key_code,
  input  logic       tick_1hz,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heat_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TICKS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [3:0]    w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt;
  logic [2:0]    r_digit_cnt, w_digit_cnt_nxt;
  logic [CW-1:0] r_done_cnt, w_done_cnt_nxt;
  logic          r_heat_on, r_done;

  logic          w_key_digit, w_key_start, w_key_stop, w_key_clear;
  logic          w_time_zero, w_can_start, w_can_shift, w_zero_all;
  logic [3:0]    w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones;
  logic          w_dec_zero;

  assign w_key_digit = key_pulse && is_digit(key_code);
  assign w_key_start = key_pulse && (key_code == KEY_START);
  assign w_key_stop  = key_pulse && (key_code == KEY_STOP);
  assign w_key_clear = key_pulse && (key_code == KEY_CLEAR);

  assign w_time_zero = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                       (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
  assign w_can_start = w_key_start && door_closed && !w_time_zero;
  assign w_can_shift = w_key_digit && (r_digit_cnt < MAX_DIGITS);

  mmss_decrement u_dec (
    .i_min_tens (r_min_tens),
    .i_min_ones (r_min_ones),
    .i_sec_tens (r_sec_tens),
    .i_sec_ones (r_sec_ones),
    .o_min_tens (w_dec_min_tens),
    .o_min_ones (w_dec_min_ones),
    .o_sec_tens (w_dec_sec_tens),
    .o_sec_ones (w_dec_sec_ones),
    .o_zero     (w_dec_zero)
  );

  // Next-state and next-datapath decode; CLEAR outranks everything, then
  // STOP/door-open, then START, then tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_min_tens_nxt  = r_min_tens;
    w_min_ones_nxt  = r_min_ones;
    w_sec_tens_nxt  = r_sec_tens;
    w_sec_ones_nxt  = r_sec_ones;
    w_digit_cnt_nxt = r_digit_cnt;
    w_done_cnt_nxt  = r_done_cnt;
    w_zero_all      = 1'b0;

    if (w_key_clear) begin
      w_zero_all = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_digit) begin
            w_state_nxt = ST_ENTRY;
            if (w_can_shift) begin
              w_min_tens_nxt  = r_min_ones;
              w_min_ones_nxt  = r_sec_tens;
              w_sec_tens_nxt  = r_sec_ones;
              w_sec_ones_nxt  = key_code;
              w_digit_cnt_nxt = r_digit_cnt + 3'd1;
            end
          end
        end

        ST_ENTRY: begin
          if (w_key_stop) begin
            w_zero_all = 1'b1;
          end else if (w_can_start) begin
            w_state_nxt = ST_RUN;
          end else if (w_can_shift) begin
            w_min_tens_nxt  = r_min_ones;
            w_min_ones_nxt  = r_sec_tens;
            w_sec_tens_nxt  = r_sec_ones;
            w_sec_ones_nxt  = key_code;
            w_digit_cnt_nxt = r_digit_cnt + 3'd1;
          end
        end

        ST_RUN: begin
          if (w_key_stop || !door_closed) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick_1hz) begin
            w_min_tens_nxt = w_dec_min_tens;
            w_min_ones_nxt = w_dec_min_ones;
            w_sec_tens_nxt = w_dec_sec_tens;
            w_sec_ones_nxt = w_dec_sec_ones;
            if (w_dec_zero) begin
              w_state_nxt     = ST_DONE;
              w_done_cnt_nxt  = '0;
              w_digit_cnt_nxt = 3'd0;
            end
          end
        end

        ST_PAUSE: begin
          if (w_key_stop) begin
            w_zero_all = 1'b1;
          end else if (w_can_start) begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_DONE: begin
          if (key_pulse) begin
            w_zero_all = 1'b1;
          end else if (tick_1hz) begin
            if (r_done_cnt == DONE_LAST) begin
              w_zero_all = 1'b1;
            end else begin
              w_done_cnt_nxt = r_done_cnt + CW'(1);
            end
          end
        end

        default: begin
          w_zero_all = 1'b1;
        end
      endcase
    end

    if (w_zero_all) begin
      w_state_nxt     = ST_IDLE;
      w_min_tens_nxt  = 4'd0;
      w_min_ones_nxt  = 4'd0;
      w_sec_tens_nxt  = 4'd0;
      w_sec_ones_nxt  = 4'd0;
      w_digit_cnt_nxt = 3'd0;
      w_done_cnt_nxt  = '0;
    end
  end

  // State, digit and counter registers; heat_on/done are registered from
  // the next state so they line up exactly with RUN/DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_min_tens  <= 4'd0;
      r_min_ones  <= 4'd0;
      r_sec_tens  <= 4'd0;
      r_sec_ones  <= 4'd0;
      r_digit_cnt <= 3'd0;
      r_done_cnt  <= '0;
      r_heat_on   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_min_tens  <= w_min_tens_nxt;
      r_min_ones  <= w_min_ones_nxt;
      r_sec_tens  <= w_sec_tens_nxt;
      r_sec_ones  <= w_sec_ones_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_done_cnt  <= w_done_cnt_nxt;
      r_heat_on   <= (w_state_nxt == ST_RUN);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign min_tens = r_min_tens;
  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign heat_on  = r_heat_on;
  assign done     = r_done;
  assign state    = r_state;

endmodule

// File: tb/tb_time_entry_counter.sv
// Self-checking bench for time_entry_counter: a table of single-cycle
// vectors followed by a hand-written full 01:30 cook and done-hold sequence.
module tb_time_entry_counter;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] K_START = 4'd10;
  localparam logic [3:0] K_STOP  = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_pulse;
  logic [3:0] key_code;
  logic       tick_1hz;
  logic       door_closed;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heat_on, done;
  logic [2:0] state;

  always #5 clk = ~clk;

  time_entry_counter #(.DONE_TICKS(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_pulse   (key_pulse),
    .key_code    (key_code),
    .tick_1hz    (tick_1hz),
    .door_closed (door_closed),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .heat_on     (heat_on),
    .done        (done),
    .state       (state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] dg;
    logic        heat;
    logic        dn;
  } exp_t;

  typedef struct packed {
    logic       kp;
    logic [3:0] kc;
    logic       tk;
    logic       dr;
    logic       rs;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic exp_t ex(input logic [2:0] st, input logic [15:0] dg);
    exp_t r;
    r.st   = st;
    r.dg   = dg;
    r.heat = (st == S_RUN);
    r.dn   = (st == S_DONE);
    return r;
  endfunction

  // Integer-seconds reference for ordinary MM:SS values (seconds < 60).
  function automatic logic [15:0] to_bcd(input int total);
    int mm, ss;
    mm = total / 60;
    ss = total % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic vec_t mv(input logic kp, input logic [3:0] kc, input logic tk,
                              input logic dr, input logic rs,
                              input logic [2:0] st, input logic [15:0] dg);
    vec_t v;
    v.kp = kp; v.kc = kc; v.tk = tk; v.dr = dr; v.rs = rs;
    v.e  = ex(st, dg);
    return v;
  endfunction

  task automatic add_key(input logic [3:0] kc, input logic [2:0] st, input logic [15:0] dg);
    vecs.push_back(mv(1'b1, kc, 1'b0, 1'b1, 1'b1, st, dg));
  endtask

  task automatic add_tick(input logic [2:0] st, input logic [15:0] dg);
    vecs.push_back(mv(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, st, dg));
  endtask

  task automatic step(input logic kp, input logic [3:0] kc, input logic tk,
                      input logic dr, input logic rs, input exp_t e, input string nm);
    exp_t want, got;
    key_pulse   = kp;
    key_code    = kc;
    tick_1hz    = tk;
    door_closed = dr;
    rstn        = rs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want     = sb_q.pop_front();
    got.st   = state;
    got.dg   = {min_tens, min_ones, sec_tens, sec_ones};
    got.heat = heat_on;
    got.dn   = done;
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got state=%0d time=%h heat=%b done=%b, want state=%0d time=%h heat=%b done=%b",
               nm, got.st, got.dg, got.heat, got.dn, want.st, want.dg, want.heat, want.dn);
    end
  endtask

  initial begin
    rstn = 1'b0; key_pulse = 1'b0; key_code = 4'd0; tick_1hz = 1'b0; door_closed = 1'b1;

    // reset and idle behaviour
    vecs.push_back(mv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, S_IDLE, 16'h0000));
    vecs.push_back(mv(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, S_IDLE, 16'h0000));
    add_key(K_STOP,  S_IDLE, 16'h0000);
    add_key(K_START, S_IDLE, 16'h0000);
    add_tick(S_IDLE, 16'h0000);
    // five digits, fifth ignored, tick in ENTRY ignored
    add_key(4'd1, S_ENTRY, 16'h0001);
    add_key(4'd2, S_ENTRY, 16'h0012);
    add_key(4'd3, S_ENTRY, 16'h0123);
    add_key(4'd4, S_ENTRY, 16'h1234);
    add_key(4'd5, S_ENTRY, 16'h1234);
    add_tick(S_ENTRY, 16'h1234);
    add_key(K_CLEAR, S_IDLE, 16'h0000);
    // 01:00 -> 00:59, digit in RUN ignored
    add_key(4'd1, S_ENTRY, 16'h0001);
    add_key(4'd0, S_ENTRY, 16'h0010);
    add_key(4'd0, S_ENTRY, 16'h0100);
    add_key(K_START, S_RUN, 16'h0100);
    add_key(4'd7, S_RUN, 16'h0100);
    add_tick(S_RUN, 16'h0059);
    add_key(K_CLEAR, S_IDLE, 16'h0000);
    // 10:00 -> 09:59
    add_key(4'd1, S_ENTRY, 16'h0001);
    add_key(4'd0, S_ENTRY, 16'h0010);
    add_key(4'd0, S_ENTRY, 16'h0100);
    add_key(4'd0, S_ENTRY, 16'h1000);
    add_key(K_START, S_RUN, 16'h1000);
    add_tick(S_RUN, 16'h0959);
    add_key(K_CLEAR, S_IDLE, 16'h0000);
    // 00:99 accepted and decremented to 00:98
    add_key(4'd9, S_ENTRY, 16'h0009);
    add_key(4'd9, S_ENTRY, 16'h0099);
    add_key(K_START, S_RUN, 16'h0099);
    add_tick(S_RUN, 16'h0098);
    add_key(K_CLEAR, S_IDLE, 16'h0000);
    // door opens with a tick, restart rules, STOP+tick, STOP in PAUSE
    add_key(4'd1, S_ENTRY, 16'h0001);
    add_key(4'd0, S_ENTRY, 16'h0010);
    add_key(K_START, S_RUN, 16'h0010);
    vecs.push_back(mv(1'b0, 4'd0,    1'b1, 1'b0, 1'b1, S_PAUSE, 16'h0010));
    vecs.push_back(mv(1'b1, K_START, 1'b0, 1'b0, 1'b1, S_PAUSE, 16'h0010));
    add_key(K_START, S_RUN, 16'h0010);
    add_tick(S_RUN, 16'h0009);
    vecs.push_back(mv(1'b1, K_STOP,  1'b1, 1'b1, 1'b1, S_PAUSE, 16'h0009));
    add_tick(S_PAUSE, 16'h0009);
    add_key(K_STOP, S_IDLE, 16'h0000);
    // START at 00:00 ignored, STOP in ENTRY clears, door-open START ignored
    add_key(4'd0, S_ENTRY, 16'h0000);
    add_key(K_START, S_ENTRY, 16'h0000);
    add_key(K_STOP, S_IDLE, 16'h0000);
    add_key(4'd3, S_ENTRY, 16'h0003);
    vecs.push_back(mv(1'b1, K_START, 1'b0, 1'b0, 1'b1, S_ENTRY, 16'h0003));
    add_key(K_START, S_RUN, 16'h0003);
    vecs.push_back(mv(1'b1, K_CLEAR, 1'b1, 1'b1, 1'b1, S_IDLE, 16'h0000));
    // reset mid-RUN at 05:00 with a key and tick present; count restarts at 0
    add_key(4'd5, S_ENTRY, 16'h0005);
    add_key(4'd0, S_ENTRY, 16'h0050);
    add_key(4'd0, S_ENTRY, 16'h0500);
    add_key(K_START, S_RUN, 16'h0500);
    vecs.push_back(mv(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, S_IDLE, 16'h0000));
    add_key(4'd7, S_ENTRY, 16'h0007);
    add_key(4'd1, S_ENTRY, 16'h0071);
    add_key(4'd2, S_ENTRY, 16'h0712);
    add_key(4'd3, S_ENTRY, 16'h7123);
    add_key(4'd4, S_ENTRY, 16'h7123);
    add_key(K_CLEAR, S_IDLE, 16'h0000);
    // reach DONE, leave it with a key; digit count must be zero afterwards
    add_key(4'd2, S_ENTRY, 16'h0002);
    add_key(K_START, S_RUN, 16'h0002);
    add_tick(S_RUN, 16'h0001);
    add_tick(S_DONE, 16'h0000);
    add_key(4'd4, S_IDLE, 16'h0000);
    add_key(4'd8, S_ENTRY, 16'h0008);
    add_key(4'd1, S_ENTRY, 16'h0081);
    add_key(4'd2, S_ENTRY, 16'h0812);
    add_key(4'd3, S_ENTRY, 16'h8123);
    add_key(4'd5, S_ENTRY, 16'h8123);
    add_key(K_CLEAR, S_IDLE, 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].kp, vecs[i].kc, vecs[i].tk, vecs[i].dr, vecs[i].rs, vecs[i].e,
           $sformatf("vec%0d", i));
    end

    // Full 01:30 cook, then done held for three ticks.
    step(1'b1, 4'd1, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0001), "cook_k1");
    step(1'b1, 4'd3, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0013), "cook_k3");
    step(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0130), "cook_k0");
    step(1'b1, K_START, 1'b0, 1'b1, 1'b1, ex(S_RUN, 16'h0130), "cook_start");
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, ex(S_RUN, 16'h0130), "cook_notick");
    for (int k = 1; k <= 90; k++) begin
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1,
           ex((k == 90) ? S_DONE : S_RUN, to_bcd(90 - k)), $sformatf("cook_tick%0d", k));
    end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, ex(S_DONE, 16'h0000), "done_idle_cycle");
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1,
           ex((j < 3) ? S_DONE : S_IDLE, 16'h0000), $sformatf("done_tick%0d", j));
    end
    step(1'b1, 4'd1, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0001), "after_done_k1");
    step(1'b1, 4'd2, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0012), "after_done_k2");
    step(1'b1, 4'd3, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h0123), "after_done_k3");
    step(1'b1, 4'd4, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h1234), "after_done_k4");
    step(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, ex(S_ENTRY, 16'h1234), "after_done_k9");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
